// File: rtl/command_decoder_pkg.sv
// Shared opcode, status-word and FIFO constants for the command decoder slice.
package command_decoder_pkg;

  typedef enum logic [3:0] {
    OP_NOP         = 4'h0,
    OP_REG_WRITE   = 4'h1,
    OP_REG_READ    = 4'h2,
    OP_PIXEL_WRITE = 4'h3,
    OP_SET_ADDR    = 4'h4,
    OP_CLEAR_ERR   = 4'h5
  } opcode_e;

  localparam logic [3:0]  STATUS_IDX         = 4'd15;
  localparam int unsigned STAT_OVF_BIT       = 15;
  localparam int unsigned STAT_ILL_BIT       = 14;
  localparam int unsigned STAT_LVL_MSB       = 3;
  localparam int unsigned STAT_LVL_LSB       = 0;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } pixel_entry_t;

  function automatic logic [15:0] status_word(input logic ovf, input logic ill,
                                              input logic [3:0] level);
    logic [15:0] w;
    w = '0;
    w[STAT_OVF_BIT] = ovf;
    w[STAT_ILL_BIT] = ill;
    w[STAT_LVL_MSB:STAT_LVL_LSB] = level;
    return w;
  endfunction

endpackage

// File: rtl/command_decoder_if.sv
// Pixel stream handshake: FIFO head toward the draw engine.
interface command_decoder_if;
  logic        valid;
  logic        ready;
  logic [15:0] addr;
  logic [15:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/pixel_fifo.sv
// Pixel FIFO: registered storage, head presented combinationally from the read pointer.
module pixel_fifo
  import command_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  pixel_entry_t           push_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  command_decoder_if.master      pix
);

  localparam int unsigned AW = $clog2(DEPTH);

  pixel_entry_t   mem_q [DEPTH];
  pixel_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic           pop;

  assign empty = (level_q == '0);
  assign full  = level_q[AW];
  assign level = level_q;
  assign pop   = !empty && pix.ready;

  assign pix.valid = !empty;
  assign pix.addr  = mem_q[rd_ptr_q].addr;
  assign pix.data  = mem_q[rd_ptr_q].data;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the head reads back as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/command_decoder.sv
// Command decoder: register file, address counter, sticky error flags and pixel FIFO.
module command_decoder
  import command_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        commandClk,
  input  logic        reset,
  input  logic [15:0] commandIn,
  input  logic [15:0] dataIn,
  output logic [15:0] readData,
  output logic        pixelValid,
  input  logic        pixelReady,
  output logic [15:0] pixelAddr,
  output logic [15:0] pixelData,
  output logic [3:0]  fifoLevel,
  output logic        errorFlag
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    idx;
  logic          unused_cmd_bits;
  logic [15:0]   regs_q [16];
  logic [15:0]   regs_d [16];
  logic [15:0]   read_data_q, read_data_d;
  logic [15:0]   cur_addr_q, cur_addr_d;
  logic          ovf_q, ovf_d;
  logic          ill_q, ill_d;
  logic          push, full, empty, pop;
  logic [LW-1:0] level;
  pixel_entry_t  push_entry;

  command_decoder_if pix_if ();

  assign idx             = commandIn[3:0];
  assign unused_cmd_bits = ^commandIn[11:4];
  assign pop             = !empty && pixelReady;
  assign push_entry      = '{addr: cur_addr_q, data: dataIn};

  assign pix_if.ready = pixelReady;
  assign pixelValid   = pix_if.valid;
  assign pixelAddr    = pix_if.addr;
  assign pixelData    = pix_if.data;
  assign fifoLevel    = 4'(level);
  assign readData     = read_data_q;
  assign errorFlag    = ovf_q | ill_q;

  always_comb begin
    regs_d      = regs_q;
    read_data_d = read_data_q;
    cur_addr_d  = cur_addr_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    push        = 1'b0;
    case (opcode_e'(commandIn[15:12]))
      OP_NOP: ;
      OP_REG_WRITE: begin
        if (idx != STATUS_IDX) regs_d[idx] = dataIn;
      end
      OP_REG_READ: begin
        read_data_d = (idx == STATUS_IDX) ? status_word(ovf_q, ill_q, fifoLevel)
                                          : regs_q[idx];
      end
      // A push into a full FIFO is still taken when the head leaves this cycle.
      OP_PIXEL_WRITE: begin
        if (!full || pop) begin
          push       = 1'b1;
          cur_addr_d = cur_addr_q + 16'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_SET_ADDR: cur_addr_d = dataIn;
      OP_CLEAR_ERR: begin
        ovf_d = 1'b0;
        ill_d = 1'b0;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge commandClk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      read_data_q <= '0;
      cur_addr_q  <= '0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      read_data_q <= read_data_d;
      cur_addr_q  <= cur_addr_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (commandClk),
    .rst       (reset),
    .push      (push),
    .push_entry(push_entry),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .pix       (pix_if)
  );

endmodule

// File: tb/tb_command_decoder.sv
// Bench for command_decoder: vector table for register/status behaviour, scoreboard for pixel stream.
module tb_command_decoder;
  import command_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] commandIn;
  logic [15:0] dataIn;
  logic [15:0] readData;
  logic [3:0]  fifoLevel;
  logic        errorFlag;

  always #5 clk = ~clk;

  command_decoder_if pix_if ();

  command_decoder #(
    .FIFO_DEPTH(8)
  ) dut (
    .commandClk(clk),
    .reset     (reset),
    .commandIn (commandIn),
    .dataIn    (dataIn),
    .readData  (readData),
    .pixelValid(pix_if.valid),
    .pixelReady(pix_if.ready),
    .pixelAddr (pix_if.addr),
    .pixelData (pix_if.data),
    .fifoLevel (fifoLevel),
    .errorFlag (errorFlag)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] dat;
    logic        rdy;
    logic [15:0] rd;
    logic [3:0]  lvl;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];
  logic [15:0] popped[$];

  int          m_level;
  logic [15:0] m_addr;
  logic [15:0] m_rd;
  logic        m_ovf;
  logic        m_ill;
  logic [15:0] m_regs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_level = 0;
    m_addr  = '0;
    m_rd    = '0;
    m_ovf   = 1'b0;
    m_ill   = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    sb.delete();
  endtask

  // Called at a negedge: apply one command, check any pop, advance one edge, check state.
  task automatic drive(input logic [15:0] cmd, input logic [15:0] dat, input logic rdy);
    logic        mpop;
    logic        mpush;
    logic [3:0]  op;
    logic [3:0]  idx;
    logic [31:0] exp;
    commandIn    = cmd;
    dataIn       = dat;
    pix_if.ready = rdy;
    #1;
    mpop  = (m_level != 0) && rdy;
    mpush = 1'b0;
    chk("pixelValid", {31'b0, pix_if.valid}, {31'b0, (m_level != 0)});
    if (mpop) begin
      exp = sb.pop_front();
      chk("pop_head", {pix_if.addr, pix_if.data}, exp);
      popped.push_back(pix_if.addr);
    end
    op  = cmd[15:12];
    idx = cmd[3:0];
    case (op)
      4'h0: ;
      4'h1: if (idx != 4'hF) m_regs[idx] = dat;
      4'h2: m_rd = (idx == 4'hF) ? {m_ovf, m_ill, 10'b0, 4'(m_level)} : m_regs[idx];
      4'h3: begin
        if (m_level < 8 || mpop) begin
          sb.push_back({m_addr, dat});
          m_addr = m_addr + 16'd1;
          mpush  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      4'h4: m_addr = dat;
      4'h5: begin
        m_ovf = 1'b0;
        m_ill = 1'b0;
      end
      default: m_ill = 1'b1;
    endcase
    m_level = m_level + int'(mpush) - int'(mpop);
    @(posedge clk);
    @(negedge clk);
    chk("readData", {16'b0, readData}, {16'b0, m_rd});
    chk("fifoLevel", {28'b0, fifoLevel}, m_level);
    chk("errorFlag", {31'b0, errorFlag}, {31'b0, m_ovf | m_ill});
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    commandIn    = 16'h3000;
    dataIn       = 16'hAAAA;
    pix_if.ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("rst_level", {28'b0, fifoLevel}, 32'd0);
    chk("rst_valid", {31'b0, pix_if.valid}, 32'd0);
    chk("rst_readData", {16'b0, readData}, 32'd0);
    chk("rst_head", {pix_if.addr, pix_if.data}, 32'd0);
    chk("rst_errorFlag", {31'b0, errorFlag}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{16'h1003, 16'hBEEF, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h2003, 16'h0000, 1'b0, 16'hBEEF, 4'd0, 1'b0});
    vecs.push_back('{16'h200F, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h100F, 16'h1234, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h200F, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h1000, 16'h5A5A, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h100E, 16'hA5A5, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h2000, 16'h0000, 1'b0, 16'h5A5A, 4'd0, 1'b0});
    vecs.push_back('{16'h200E, 16'h0000, 1'b0, 16'hA5A5, 4'd0, 1'b0});
    vecs.push_back('{16'h0FF3, 16'hFFFF, 1'b1, 16'hA5A5, 4'd0, 1'b0});
    vecs.push_back('{16'h9000, 16'h0000, 1'b0, 16'hA5A5, 4'd0, 1'b1});
    vecs.push_back('{16'h200F, 16'h0000, 1'b0, 16'h4000, 4'd0, 1'b1});
    vecs.push_back('{16'h5000, 16'h0000, 1'b0, 16'h4000, 4'd0, 1'b0});
    vecs.push_back('{16'h200F, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0});
    vecs.push_back('{16'h2003, 16'h0000, 1'b0, 16'hBEEF, 4'd0, 1'b0});

    model_clear();
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].dat, vecs[i].rdy);
      chk($sformatf("vec%0d_rd", i), {16'b0, readData}, {16'b0, vecs[i].rd});
      chk($sformatf("vec%0d_lvl", i), {28'b0, fifoLevel}, {28'b0, vecs[i].lvl});
      chk($sformatf("vec%0d_err", i), {31'b0, errorFlag}, {31'b0, vecs[i].err});
    end

    // Address wrap through 0xFFFF with the draw engine always ready.
    popped.delete();
    drive(16'h4000, 16'hFFFE, 1'b1);
    drive(16'h3000, 16'h0011, 1'b1);
    drive(16'h3000, 16'h0022, 1'b1);
    drive(16'h3000, 16'h0033, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'h0000, 16'h0000, 1'b1);
    chk("wrap_pop0", {16'b0, (popped.size() > 0) ? popped[0] : 16'hDEAD}, 32'h0000FFFE);
    chk("wrap_pop1", {16'b0, (popped.size() > 1) ? popped[1] : 16'hDEAD}, 32'h0000FFFF);
    chk("wrap_pop2", {16'b0, (popped.size() > 2) ? popped[2] : 16'hDEAD}, 32'h00000000);
    chk("wrap_drained", {28'b0, fifoLevel}, 32'd0);

    // Fill with the draw engine stalled; the ninth write overflows.
    drive(16'h4000, 16'h0100, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(16'h3000, 16'hD000 + 16'(i), 1'b0);
      if (i == 0) begin
        chk("latency_valid", {31'b0, pix_if.valid}, 32'd1);
        chk("latency_head", {pix_if.addr, pix_if.data}, 32'h0100D000);
      end
    end
    chk("full_level", {28'b0, fifoLevel}, 32'd8);
    chk("full_err", {31'b0, errorFlag}, 32'd1);
    chk("stall_head", {pix_if.addr, pix_if.data}, 32'h0100D000);
    drive(16'h200F, 16'h0000, 1'b0);
    chk("status_ovf", {16'b0, readData}, 32'h00008008);
    drive(16'h5000, 16'h0000, 1'b0);
    drive(16'h200F, 16'h0000, 1'b0);
    chk("status_clr", {16'b0, readData}, 32'h00000008);

    // Push into a full FIFO while the head leaves.
    drive(16'h3000, 16'hE000, 1'b1);
    chk("full_pp_level", {28'b0, fifoLevel}, 32'd8);
    chk("full_pp_err", {31'b0, errorFlag}, 32'd0);
    drive(16'h200F, 16'h0000, 1'b0);
    chk("full_pp_status", {16'b0, readData}, 32'h00000008);

    // Illegal opcode.
    drive(16'h9000, 16'h0000, 1'b0);
    chk("illegal_err", {31'b0, errorFlag}, 32'd1);
    drive(16'h200F, 16'h0000, 1'b0);
    chk("illegal_status", {16'b0, readData}, 32'h00004008);

    // Reset with five entries queued.
    for (int i = 0; i < 3; i++) drive(16'h0000, 16'h0000, 1'b1);
    chk("pre_reset_level", {28'b0, fifoLevel}, 32'd5);
    do_reset();
    drive(16'h3000, 16'h7777, 1'b0);
    chk("post_reset_head", {pix_if.addr, pix_if.data}, 32'h00007777);
    for (int i = 0; i < 2; i++) drive(16'h0000, 16'h0000, 1'b1);
    chk("final_level", {28'b0, fifoLevel}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/command_decoder.md
COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the pixel FIFO depth in entries (power of two).
REQ-002 The block SHALL have port commandClk, input, 1 bit: single clock, rising edge; it is the same clock as the upstream command interface.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port commandIn, input, 16 bits: command word from the interface; 0 = NOP.
REQ-005 The block SHALL have port dataIn, input, 16 bits: data word accompanying commandIn.
REQ-006 The block SHALL have port readData, output, 16 bits: register read-back to the interface's GPU read-data input.
REQ-007 The block SHALL have port pixelValid, output, 1 bit: FIFO head is valid.
REQ-008 The block SHALL have port pixelReady, input, 1 bit: the draw engine accepts the head.
REQ-009 The block SHALL have port pixelAddr, output, 16 bits: FIFO head address.
REQ-010 The block SHALL have port pixelData, output, 16 bits: FIFO head data.
REQ-011 The block SHALL have port fifoLevel, output, 4 bits: FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 The block SHALL have port errorFlag, output, 1 bit: OR of the sticky overflow and illegal flags.

Function
REQ-013 commandIn and dataIn SHALL be sampled every rising edge; decode is on opcode = commandIn[15:12] and idx = commandIn[3:0].
REQ-014 Opcode 0x0 (NOP) SHALL have no effect.
REQ-015 Opcode 0x1 (REG_WRITE) SHALL set reg[idx] = dataIn for idx 0..14; a REG_WRITE with idx 15 SHALL be ignored.
REQ-016 Opcode 0x2 (REG_READ) SHALL set readData = reg[idx] at the same edge; idx 15 SHALL return status = {overflow, illegal, 10'b0, fifoLevel}; readData SHALL hold its value until the next REG_READ.
REQ-017 Opcode 0x3 (PIXEL_WRITE) SHALL push {curAddr, dataIn} into the FIFO; on an accepted push, curAddr SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-018 Opcode 0x4 (SET_ADDR) SHALL set curAddr = dataIn.
REQ-019 Opcode 0x5 (CLEAR_ERR) SHALL clear the overflow and illegal flags; if another error event occurs in the same cycle, the set SHALL win.
REQ-020 Opcodes 0x6..0xF SHALL set the illegal flag (sticky) and have no other effect.
REQ-021 A pop SHALL occur on a rising edge when pixelValid && pixelReady; pixelValid SHALL be high exactly when fifoLevel != 0.
REQ-022 A push SHALL be accepted if fifoLevel < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-023 A rejected push SHALL leave the data, curAddr and level unchanged and SHALL set the overflow flag (sticky).
REQ-024 Simultaneous push and pop SHALL leave the level unchanged.
REQ-025 Simultaneous push and pop with level 0 SHALL be impossible, since pixelValid is low at level 0; the pushed entry SHALL appear on the head the next cycle.
REQ-026 The FIFO SHALL be first-in first-out; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Push-to-head latency SHALL be 1 cycle: an entry pushed at edge N SHALL be visible on pixelAddr/pixelData after edge N when the FIFO was empty.
REQ-028 pixelAddr and pixelData SHALL be stable while pixelValid && !pixelReady.

Reset
REQ-029 While reset is high at a rising edge, the block SHALL clear: readData = 0, all reg[0..14] = 0, curAddr = 0, FIFO empty (fifoLevel = 0, pixelValid = 0), overflow = illegal = 0, errorFlag = 0.
REQ-030 Reset asserted mid-burst SHALL discard all FIFO contents, and the command sampled in that cycle SHALL be ignored.
REQ-031 pixelAddr and pixelData SHALL be 0 after reset.

Structure
REQ-032 A shared package SHALL hold the opcode constants (NOP..CLEAR_ERR), STATUS_IDX = 15, status bit positions (overflow = 15, illegal = 14, level = 3:0) and the default FIFO_DEPTH.
REQ-033 The FIFO SHALL be a sub-module, pixel_fifo (push/pop/full/empty/level, synchronous reset), instantiated once.

Verification
REQ-034 The bench SHALL check: REG_WRITE idx 3, data 0xBEEF, then REG_READ idx 3 -> readData = 0xBEEF one edge later; REG_WRITE idx 15 -> status unchanged.
REQ-035 The bench SHALL check: SET_ADDR 0xFFFE, then 3 PIXEL_WRITE 0x11/0x22/0x33 with pixelReady = 1 -> pops at addr 0xFFFE, 0xFFFF, 0x0000 in order with matching data.
REQ-036 The bench SHALL check: pixelReady = 0 and 9 PIXEL_WRITE -> fifoLevel = 8, 9th dropped, REG_READ 15 -> 0x8008; CLEAR_ERR -> 0x0008.
REQ-037 The bench SHALL check: FIFO full, PIXEL_WRITE together with pixelReady = 1 -> push accepted, level stays 8, no overflow.
REQ-038 The bench SHALL check: opcode 0x9 -> illegal set, errorFlag = 1, REG_READ 15 -> 0x4000 | level.
REQ-039 The bench SHALL check: reset for 1 cycle with 5 entries queued -> fifoLevel = 0, pixelValid = 0, readData = 0, next PIXEL_WRITE at addr 0.
